descrambler_rx: RTL
===================

DESCRAMBLER_RX -- requirements
Module: descrambler_rx

Interface
REQ-001 The block SHALL have parameter LENGTH_NUMOF_BIT, default 12, the width of the frame length field.
REQ-002 The block SHALL have parameter SEED, default 7'b1111111, the LFSR state loaded at frame start.
REQ-003 The block SHALL have port clk, input, 1, the clock; all logic samples on the rising edge.
REQ-004 The block SHALL have port reset, input, 1, the reset; synchronous, active-high.
REQ-005 The block SHALL have port start, input, 1, a one-cycle frame-start strobe, honoured only in IDLE.
REQ-006 The block SHALL have port length, input, LENGTH_NUMOF_BIT, the frame length code, sampled when start is accepted; the frame carries length+1 bits.
REQ-007 The block SHALL have port validIn, input, 1, which qualifies dataIn.
REQ-008 The block SHALL have port dataIn, input, 1, the scrambled serial bit.
REQ-009 The block SHALL have port dataOut, output, 1, the descrambled serial bit.
REQ-010 The block SHALL have port validOut, output, 1, which qualifies dataOut.
REQ-011 The block SHALL have port byteOut, output, 8, the packed descrambled byte, LSB first received.
REQ-012 The block SHALL have port byteValid, output, 1, a one-cycle strobe qualifying byteOut.
REQ-013 The block SHALL have port byteLast, output, 1, asserted with byteValid on the final byte of the frame.
REQ-014 The block SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-015 The block SHALL have port done, output, 1, a one-cycle strobe at frame end.

Function
REQ-016 The FSM SHALL have the states IDLE, INIT, DESCRAMBLE and FLUSH, with these transitions:
- IDLE->INIT on start.
- INIT->DESCRAMBLE unconditionally.
- DESCRAMBLE->FLUSH when the accepted-bit count equals the latched length and validIn is high.
- FLUSH->IDLE unconditionally.
REQ-017 In INIT, the LFSR SHALL load SEED, the bit counter SHALL clear to 0, and the byte shift register and its bit index SHALL clear.
REQ-018 The keystream SHALL be fb = s[6] XOR s[3] (polynomial x^7+x^4+1), and the state SHALL update to {s[5:0], fb} only on accepted bits.
REQ-019 A bit SHALL be accepted only when the state is DESCRAMBLE and validIn is 1; validIn low SHALL stall the LFSR, the counter and the packer.
REQ-020 The descrambled bit SHALL be dataIn XOR fb, registered; dataOut/validOut SHALL appear one cycle after acceptance.
REQ-021 Accepted bits SHALL pack into byteOut LSB first, and byteValid SHALL pulse one cycle after the 8th bit of each byte is accepted.
REQ-022 In FLUSH, a partial byte (1-7 bits) SHALL be emitted zero-padded in the upper bits, with byteValid=1 and byteLast=1.
REQ-023 If the frame ends on a byte boundary, byteLast SHALL accompany the final full byte's byteValid, and FLUSH SHALL emit no extra byte.
REQ-024 done SHALL pulse for exactly one cycle while the state is FLUSH.
REQ-025 start SHALL be ignored outside IDLE, and length SHALL be latched only on an accepted start.
REQ-026 validIn outside DESCRAMBLE SHALL be ignored, and no output SHALL respond to it.
REQ-027 The bit counter SHALL be LENGTH_NUMOF_BIT wide with no wrap inside a frame; the maximum frame is 2^LENGTH_NUMOF_BIT bits.
REQ-028 A start in the same cycle as done SHALL be ignored; the earliest new start is accepted one cycle after FLUSH.

Reset
REQ-029 Reset SHALL force the state to IDLE and the LFSR to SEED.
REQ-030 Reset SHALL clear the counter and the packer, and drive dataOut, validOut, byteOut, byteValid, byteLast, busy and done to 0.
REQ-031 Reset SHALL take priority over start and validIn in the same cycle.
REQ-032 Reset mid-frame SHALL discard the partial frame with no done or byteValid pulse.

Structure
REQ-033 The state encodings (IDLE=2'b00, INIT=2'b01, DESCRAMBLE=2'b10, FLUSH=2'b11), LENGTH_NUMOF_BIT and SEED SHALL reside in a shared package used by both transmitter and receiver.
REQ-034 The LFSR SHALL be one sub-module, lfsr7_descrambler (ports clk, load, advance, bitIn, bitOut), reusable against the transmit scrambler.

Verification
REQ-035 Scenario: start with length=15, then 16 bits of dataIn=0 with validIn=1 continuously -> byteOut 0x70 then 0x4F, the second with byteLast=1, then done one cycle later.
REQ-036 Scenario: loopback from the transmitter with length=99 and a random payload -> 100 dataOut bits equal to the payload, 13 bytes with the last zero-padded, one done.
REQ-037 Scenario: length=15 with validIn toggling 1,0,1,0 -> output identical to REQ-035, delayed; LFSR stalled on every validIn=0 cycle.
REQ-038 Scenario: length=0, one bit dataIn=1 -> dataOut=1, byteOut=0x01 with byteLast=1, done.
REQ-039 Scenario: reset asserted after 5 accepted bits -> all outputs 0 next cycle, no byteValid or done; a following length=7 frame decodes correctly from SEED.
REQ-040 Scenario: start pulsed during DESCRAMBLE with length=3 -> ignored; the original length governs frame end.

Source files
------------

// File: rtl/descrambler_rx_pkg.sv
// Types and constants shared by the scrambler (transmit) and descrambler (receive) paths.
// Holds the frame FSM encoding, default field widths and the x^7+x^4+1 keystream tap.
package descrambler_rx_pkg;

    localparam int         LENGTH_NUMOF_BIT = 12;
    localparam logic [6:0] SEED             = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        INIT       = 2'b01,
        DESCRAMBLE = 2'b10,
        FLUSH      = 2'b11
    } scrState_t;

    function automatic logic keystreamBit(input logic [6:0] s);
        return s[6] ^ s[3];
    endfunction

endpackage

// File: rtl/descrambler_rx_lfsr.sv
// Additive x^7+x^4+1 LFSR; bitOut is bitIn XOR the current keystream bit.
// The same block scrambles on transmit and descrambles on receive.
module lfsr7_descrambler #(
    parameter logic [6:0] SEED = descrambler_rx_pkg::SEED
) (
    input  logic clk,
    input  logic load,
    input  logic advance,
    input  logic bitIn,
    output logic bitOut
);

    logic [6:0] lfsrState;
    logic       fb;

    assign fb     = descrambler_rx_pkg::keystreamBit(lfsrState);
    assign bitOut = bitIn ^ fb;

    // No reset port: the owner holds load high during its reset.
    always_ff @(posedge clk) begin
        if (load) begin
            lfsrState <= SEED;
        end else if (advance) begin
            lfsrState <= {lfsrState[5:0], fb};
        end
    end

endmodule

// File: rtl/descrambler_rx.sv
// Frame-based serial descrambler: restarts the LFSR from SEED on each frame,
// emits descrambled bits and LSB-first packed bytes, and flags the final byte.
//
// state      | meaning
// IDLE       | waiting for start; length latched when start is taken
// INIT       | LFSR loads SEED, bit counter and byte packer clear
// DESCRAMBLE | each validIn bit is descrambled, counted and packed
// FLUSH      | frame complete; done high for this one cycle
module descrambler_rx #(
    parameter int         LENGTH_NUMOF_BIT = descrambler_rx_pkg::LENGTH_NUMOF_BIT,
    parameter logic [6:0] SEED             = descrambler_rx_pkg::SEED
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [LENGTH_NUMOF_BIT-1:0] length,
    input  logic                        validIn,
    input  logic                        dataIn,
    output logic                        dataOut,
    output logic                        validOut,
    output logic [7:0]                  byteOut,
    output logic                        byteValid,
    output logic                        byteLast,
    output logic                        busy,
    output logic                        done
);
    import descrambler_rx_pkg::*;

    scrState_t                   stateQ, stateD;
    logic [LENGTH_NUMOF_BIT-1:0] lengthQ;
    logic [LENGTH_NUMOF_BIT-1:0] bitCount;
    logic [7:0]                  packReg;
    logic [7:0]                  packNext;
    logic [2:0]                  packIdx;
    logic                        accept;
    logic                        lastBit;
    logic                        lfsrLoad;
    logic                        descBit;

    assign accept   = (stateQ == DESCRAMBLE) && validIn;
    assign lastBit  = (bitCount == lengthQ);
    assign lfsrLoad = reset || (stateQ == INIT);
    assign busy     = (stateQ != IDLE);
    assign done     = (stateQ == FLUSH);

    lfsr7_descrambler #(.SEED(SEED)) uLfsr (
        .clk     (clk),
        .load    (lfsrLoad),
        .advance (accept),
        .bitIn   (dataIn),
        .bitOut  (descBit)
    );

    always_comb begin
        stateD = stateQ;
        case (stateQ)
            IDLE:       if (start) stateD = INIT;
            INIT:       stateD = DESCRAMBLE;
            DESCRAMBLE: if (validIn && lastBit) stateD = FLUSH;
            FLUSH:      stateD = IDLE;
            default:    stateD = IDLE;
        endcase
    end

    always_comb begin
        packNext = packReg | (8'(descBit) << packIdx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ    <= IDLE;
            lengthQ   <= '0;
            bitCount  <= '0;
            packReg   <= '0;
            packIdx   <= '0;
            dataOut   <= 1'b0;
            validOut  <= 1'b0;
            byteOut   <= '0;
            byteValid <= 1'b0;
            byteLast  <= 1'b0;
        end else begin
            stateQ    <= stateD;
            validOut  <= accept;
            dataOut   <= accept & descBit;
            byteValid <= 1'b0;
            byteLast  <= 1'b0;

            if ((stateQ == IDLE) && start) begin
                lengthQ <= length;
            end

            if (stateQ == INIT) begin
                bitCount <= '0;
                packReg  <= '0;
                packIdx  <= '0;
            end else if (accept) begin
                if (!lastBit) begin
                    bitCount <= bitCount + LENGTH_NUMOF_BIT'(1);
                end
                // The final bit of a frame releases whatever is packed, so a
                // partial byte leaves zero-padded alongside the FLUSH cycle.
                if ((packIdx == 3'd7) || lastBit) begin
                    byteOut   <= packNext;
                    byteValid <= 1'b1;
                    byteLast  <= lastBit;
                    packReg   <= '0;
                    packIdx   <= '0;
                end else begin
                    packReg <= packNext;
                    packIdx <= packIdx + 3'd1;
                end
            end
        end
    end

endmodule
